// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_e;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam logic [KP_COLS-1:0] KP_COL_RESET = 4'b1110;

  // Index of the lowest-numbered zero bit; only meaningful when one exists.
  function automatic logic [1:0] low_index(input logic [KP_ROWS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_ROWS - 1; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic single_low(input logic [KP_ROWS-1:0] v);
    int zeros;
    zeros = 0;
    for (int i = 0; i < KP_ROWS; i++) begin
      if (!v[i]) zeros++;
    end
    return zeros == 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-report signals of the scanner
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KP_ROWS-1:0] row_in;
  logic               clear;
  logic [KP_COLS-1:0] col_out;
  logic [3:0]         key_code;
  logic               key_valid;
  logic               key_held;
  logic [31:0]        entry;

  modport master (
    input  row_in, clear,
    output col_out, key_code, key_valid, key_held, entry
  );

  modport slave (
    output row_in, clear,
    input  col_out, key_code, key_valid, key_held, entry
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all-ones (idle level of pulled-up inputs)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with debounce and hex entry register
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_scanner_if.master   kp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

  logic [KP_ROWS-1:0] rows_s;
  logic               tick;

  kp_state_e          state_q,     state_d;
  logic [PW-1:0]      presc_q,     presc_d;
  logic [KP_COLS-1:0] col_q,       col_d;
  logic [1:0]         row_q,       row_d;
  logic [KP_ROWS-1:0] pat_q,       pat_d;
  logic [CW-1:0]      match_q,     match_d;
  logic [CW-1:0]      rel_q,       rel_d;
  logic [3:0]         key_code_q,  key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               key_held_q,  key_held_d;
  logic [31:0]        entry_q,     entry_d;

  logic [KP_COLS-1:0] col_next;
  logic [1:0]         col_idx;
  logic [CW-1:0]      match_inc;
  logic [CW-1:0]      rel_inc;
  logic [3:0]         code_now;

  sync_2ff #(.WIDTH(KP_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (kp.row_in),
    .q     (rows_s)
  );

  assign tick      = (presc_q == PS_LAST);
  assign col_next  = {col_q[KP_COLS-2:0], col_q[KP_COLS-1]};
  assign col_idx   = low_index(col_q);
  assign match_inc = match_q + 1'b1;
  assign rel_inc   = rel_q + 1'b1;
  assign code_now  = {row_q, col_idx};

  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    col_d       = col_q;
    row_d       = row_q;
    pat_d       = pat_q;
    match_d     = match_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    entry_d     = entry_q;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (single_low(rows_s)) begin
            row_d   = low_index(rows_s);
            pat_d   = rows_s;
            match_d = CW'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (rows_s == pat_q) begin
            match_d = match_inc;
            if (match_inc == CNT_DONE) begin
              key_code_d  = code_now;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              entry_d     = {entry_q[27:0], code_now};
              rel_d       = '0;
              state_d     = HELD;
            end
          end else begin
            col_d   = col_next;
            state_d = SCAN;
          end
        end
      end
      HELD: begin
        // Column stays frozen, so keys in other columns cannot disturb the release count.
        if (tick) begin
          if (rows_s == '1) begin
            if (rel_inc == CNT_DONE) begin
              rel_d      = '0;
              key_held_d = 1'b0;
              col_d      = col_next;
              state_d    = SCAN;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d = '0;
          end
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase

    if (kp.clear) entry_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      presc_q     <= '0;
      col_q       <= KP_COL_RESET;
      row_q       <= '0;
      pat_q       <= '1;
      match_q     <= '0;
      rel_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      match_q     <= match_d;
      rel_q       <= rel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      entry_q     <= entry_d;
    end
  end

  assign kp.col_out   = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.entry     = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;

  always #5 clk = ~clk;

  keypad_scanner_if kif();

  function automatic logic [3:0] model_rows(input logic [15:0] k, input logic [3:0] col);
    logic [3:0] res;
    for (int r = 0; r < 4; r++) res[r] = ~|(k[r*4 +: 4] & ~col);
    return res;
  endfunction

  assign kif.row_in = model_rows(keys, kif.col_out);

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  int         vcount = 0;
  logic [3:0] vcode;
  logic       vheld;
  logic [3:0] vcol;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n && kif.key_valid) begin
      vcount++;
      vcode = kif.key_code;
      vheld = kif.key_held;
      vcol  = kif.col_out;
      chk("valid_one_cycle", {31'b0, prev_valid}, 0);
    end
    prev_valid = rst_n & kif.key_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int v0, input int budget, output int lat, output bit got);
    lat = 0;
    got = 0;
    while (!got && lat < budget) begin
      step(1);
      lat++;
      if (vcount != v0) got = 1;
    end
  endtask

  task automatic wait_release(input string name);
    int lat;
    lat = 0;
    while (kif.key_held && lat < 30) begin
      step(1);
      lat++;
    end
    chk({name, "_release_window"}, (lat >= 11 && lat <= 14), 1);
  endtask

  // Clean press and release of key (r,c); expected code given by caller.
  task automatic do_press(input int r, input int c, input logic [3:0] exp_code);
    int         v0, lat;
    bit         got;
    logic [3:0] one, exp_col;
    one     = 4'b0001;
    exp_col = ~(one << c);
    v0 = vcount;
    keys[r*4+c] = 1'b1;
    wait_valid(v0, 40, lat, got);
    chk("press_valid_seen", got, 1);
    if (got) begin
      chk("press_latency", (lat >= 11 && lat <= 26), 1);
      chk("press_key_code", vcode, exp_code);
      chk("press_held_with_valid", vheld, 1);
      chk("press_col_frozen", vcol, exp_col);
    end
    step(6);
    chk("press_single_valid", vcount - v0, 1);
    chk("press_held_during", kif.key_held, 1);
    keys[r*4+c] = 1'b0;
    wait_release("press");
    step(2);
  endtask

  typedef struct {
    int          r;
    int          c;
    logic [3:0]  code;
    logic [31:0] entry;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          lat, v0, run;
    bit          got;
    logic [3:0]  exp_col;
    logic [31:0] model;

    tbl[0] = '{0, 1, 4'h1, 32'h0000_0001};
    tbl[1] = '{0, 2, 4'h2, 32'h0000_0012};
    tbl[2] = '{0, 3, 4'h3, 32'h0000_0123};
    tbl[3] = '{1, 0, 4'h4, 32'h0000_1234};
    tbl[4] = '{1, 1, 4'h5, 32'h0001_2345};
    tbl[5] = '{1, 2, 4'h6, 32'h0012_3456};
    tbl[6] = '{1, 3, 4'h7, 32'h0123_4567};
    tbl[7] = '{2, 0, 4'h8, 32'h1234_5678};
    tbl[8] = '{2, 1, 4'h9, 32'h2345_6789};

    kif.clear = 1'b0;
    step(3);
    chk("reset_col_out", kif.col_out, 4'b1110);
    chk("reset_key_code", kif.key_code, 0);
    chk("reset_key_valid", kif.key_valid, 0);
    chk("reset_key_held", kif.key_held, 0);
    chk("reset_entry", kif.entry, 0);
    rst_n = 1'b1;

    // Idle scan: first column step 4 cycles after reset, then 4 cycles per column.
    lat = 0;
    while (kif.col_out == 4'b1110 && lat < 10) begin
      step(1);
      lat++;
    end
    chk("idle_first_col_step", lat, 4);
    exp_col = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 4; s++) begin
        chk("idle_col_sequence", kif.col_out, exp_col);
        step(1);
      end
      exp_col = {exp_col[2:0], exp_col[3]};
    end
    chk("idle_no_valid", vcount, 0);
    chk("idle_entry", kif.entry, 0);

    do_press(2, 1, 4'h9);
    chk("clean_entry", kif.entry, 32'h0000_0009);
    chk("clean_held_low", kif.key_held, 0);

    // Bounce: key toggles every dwell, so no two consecutive ticks match.
    v0 = vcount;
    for (int i = 0; i < 3; i++) begin
      keys[9] = 1'b1;
      step(4);
      keys[9] = 1'b0;
      step(4);
    end
    chk("bounce_no_valid", vcount - v0, 0);
    keys[9] = 1'b1;
    wait_valid(v0, 40, lat, got);
    chk("bounce_valid_seen", got, 1);
    chk("bounce_latency", (lat >= 11 && lat <= 26), 1);
    chk("bounce_code", vcode, 4'h9);
    step(6);
    chk("bounce_single_valid", vcount - v0, 1);
    keys[9] = 1'b0;
    wait_release("bounce");
    step(2);

    kif.clear = 1'b1;
    step(1);
    kif.clear = 1'b0;
    chk("clear_idle", kif.entry, 0);
    for (int i = 0; i < 9; i++) begin
      do_press(tbl[i].r, tbl[i].c, tbl[i].code);
      chk("table_entry", kif.entry, tbl[i].entry);
    end

    // Rollover: second key while first is held must be ignored.
    v0 = vcount;
    keys[0] = 1'b1;
    wait_valid(v0, 40, lat, got);
    chk("roll_first_valid", got, 1);
    chk("roll_first_code", vcode, 4'h0);
    keys[15] = 1'b1;
    step(40);
    chk("roll_no_second_valid", vcount - v0, 1);
    chk("roll_still_held", kif.key_held, 1);
    keys[0]  = 1'b0;
    keys[15] = 1'b0;
    wait_release("roll");
    chk("roll_col_resumes", kif.col_out, 4'b1101);
    step(6);
    chk("roll_col_advances", kif.col_out, 4'b1011);
    step(20);
    chk("roll_no_late_valid", vcount - v0, 1);

    // Random presses against a digit-shift model of the entry register.
    model = kif.entry;
    for (int i = 0; i < 12; i++) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        kif.clear = 1'b1;
        step(1);
        kif.clear = 1'b0;
        model = 0;
      end
      do_press(r, c, 4'(r * 4 + c));
      model = (model << 4) | 32'(r * 4 + c);
      chk("rand_entry", kif.entry, model);
      step($urandom_range(1, 9));
    end

    // Clear held across the accepting tick wins over the shift.
    chk("pre_clear_entry_nonzero", (kif.entry != 0) || (model == 0), 1);
    v0 = vcount;
    kif.clear = 1'b1;
    keys[10] = 1'b1;
    wait_valid(v0, 40, lat, got);
    chk("clracc_valid_seen", got, 1);
    chk("clracc_code", kif.key_code, 4'hA);
    chk("clracc_entry", kif.entry, 0);
    kif.clear = 1'b0;
    keys[10] = 1'b0;
    wait_release("clracc");
    chk("clracc_entry_after", kif.entry, 0);
    step(2);

    do_press(1, 1, 4'h5);
    chk("pre_reset_entry", kif.entry, 32'h0000_0005);

    // Reset while debouncing key (1,3), then re-detect it.
    v0 = vcount;
    keys[7] = 1'b1;
    run = 0;
    lat = 0;
    while (run < 6 && lat < 40) begin
      step(1);
      lat++;
      run = (kif.col_out == 4'b0111) ? run + 1 : 0;
    end
    chk("rst_reached_debounce", run, 6);
    chk("rst_not_yet_accepted", vcount - v0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_col_out", kif.col_out, 4'b1110);
    chk("rst_async_key_code", kif.key_code, 0);
    chk("rst_async_key_valid", kif.key_valid, 0);
    chk("rst_async_key_held", kif.key_held, 0);
    chk("rst_async_entry", kif.entry, 0);
    step(2);
    rst_n = 1'b1;
    v0 = vcount;
    wait_valid(v0, 40, lat, got);
    chk("rst_redetect_valid", got, 1);
    chk("rst_redetect_code", vcode, 4'h7);
    step(2);
    chk("rst_redetect_entry", kif.entry, 32'h0000_0007);
    keys[7] = 1'b0;
    wait_release("rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the multiplexed 7-segment display driver: scans a 4x4 active-low hex keypad matrix, debounces presses, and reports one key code per press. Each accepted hex digit also shifts into a 32-bit entry register, which feeds the display's 32-bit `numbers` input and the CPU's I/O path as a typed-in value.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per column dwell. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive matching samples needed to accept a press or a release. Must be ≥ 2.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `row_in` input 4: keypad rows; active-low, externally pulled up; asynchronous.
- `clear` input 1: synchronous; zeroes `entry`.
- `col_out` output 4: column drive; active-low one-hot.
- `key_code` output 4: code of the last accepted key, equal to row*4 + col.
- `key_valid` output 1: one-cycle pulse when a press is accepted.
- `key_held` output 1: high from acceptance until the release is accepted.
- `entry` output 32: hex-entry shift register; newest digit in [3:0].

## Operation
- `row_in` passes through a 2-flop synchronizer. All decisions use the synchronized value `rows_s`.
- Prescaler counts 0..SCAN_DIV-1 and wraps. A `tick` is the cycle where the count = SCAN_DIV-1. Rows are sampled only on `tick`, giving a full dwell for settling.
- States:
  - **SCAN**: on tick, if exactly one bit of `rows_s` is low, latch the row index, hold the column, set match count = 1, and go to DEBOUNCE. Otherwise advance the column 0→1→2→3→0. Zero or two-plus rows low is treated as no key.
  - **DEBOUNCE**: column frozen. On tick, if `rows_s` equals the latched pattern, increment the count. Otherwise advance the column and return to SCAN. When the count reaches DEBOUNCE_SCANS: register `key_code`, pulse `key_valid` for the next cycle, shift `entry` <= {entry[27:0], key_code}, and go to HELD.
  - **HELD**: `key_held`=1, column frozen. On tick, if `rows_s` = 4'b1111, increment the release count; any low row resets it to 0. When the release count reaches DEBOUNCE_SCANS: advance the column and go to SCAN. Other keys pressed while in HELD are ignored (no rollover).
- `clear` and an accepting tick in the same cycle: `key_valid` still pulses and `key_code` updates, but `entry` = 0 (clear wins).
- `entry` shifts 8 digits, then the oldest digit drops off [31:28]. There is no saturation.
- Reset mid-press: all state returns to reset values. A key still held after reset is re-detected and reported again.

## Timing
- Reset values: `col_out`=4'b1110 (column 0), `key_code`=0, `key_valid`=0, `key_held`=0, `entry`=0, state SCAN, prescaler 0, counts 0.
- Input latency is 2 cycles (synchronizer).
- Acceptance: `key_valid` rises 1 cycle after the tick that completes the count, i.e. (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 cycles after the detection tick.
- `key_held` rises in the same cycle as `key_valid`. It falls 1 cycle after the DEBOUNCE_SCANS-th consecutive all-high tick.
- `col_out` changes only on the cycle after a tick.
- Worst-case detect delay after stable press: 4*SCAN_DIV + 2 cycles.
- Throughput: at most one `key_valid` per press/release pair.

## Structure
- Shared package `keypad_pkg`:
  - state enum {SCAN, DEBOUNCE, HELD};
  - constants KP_ROWS=4, KP_COLS=4;
  - reset column pattern 4'b1110.
- One sub-module, `sync_2ff` (parameterized width, async active-low reset to all-ones), for `row_in`. It is reusable for other board inputs.
- Prescaler, FSM, and entry register stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3; a keypad model pulls `row_in[r]` low when `col_out[c]`=0 and key (r,c) is pressed.
- Reset with no key pressed → `col_out` cycles 1110,1101,1011,0111 every 4 clk; `key_valid` never asserts; `entry`=0.
- Press key (2,1) cleanly → one `key_valid` pulse with `key_code`=4'h9; `key_held`=1 until release; `entry`=32'h0000_0009.
- Bounce: toggle (2,1) on alternate ticks for 6 ticks, then hold stable → exactly one `key_valid` (code 9), and only after 3 consecutive matching ticks.
- Press keys 1,2,...,9 in sequence, each released between presses → `entry`=32'h2345_6789 after 9 presses (digit 1 shifted out).
- While (0,0) is held, press (3,3) as well → no second `key_valid`; after both are released, HELD exits and scanning resumes.
- Assert `clear` on the `key_valid` cycle for key 4'hA → `key_code`=A, `entry`=0. Assert `rst_n`=0 during DEBOUNCE → all outputs return to reset values immediately, asynchronously.
